// File: rtl/rv32i_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// failure codes and the state decode for the "load in progress" outputs.
package rv32i_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } loader_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_LEN_ZERO = 2'd1;
    localparam logic [1:0] ERR_LEN_OVF  = 2'd2;
    localparam logic [1:0] ERR_CSUM     = 2'd3;

    function automatic logic is_loading(input loader_state_t s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Collects four stream bytes into one little-endian 32-bit word and emits a
// one-cycle word_valid pulse the cycle after the fourth byte is accepted.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_cnt,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [23:0] partial;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= '0;
            partial    <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= 1'b0;
            // clear drops any partial word; a pulse already on word_valid is unaffected
            if (clear) begin
                byte_cnt <= '0;
                partial  <= '0;
            end else if (byte_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: partial[7:0]   <= byte_data;
                    2'd1: partial[15:8]  <= byte_data;
                    2'd2: partial[23:16] <= byte_data;
                    default: begin
                        word_data  <= {byte_data, partial};
                        word_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the RV32I instruction memory: parses length,
// writes payload words, verifies the XOR checksum and gates the core reset.
module imem_loader
    import rv32i_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    loader_state_t         state, state_d;
    logic [1:0]            err_code_d;
    logic [7:0]            len_lo;
    logic [15:0]           len;
    logic [7:0]            csum;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_cnt;
    logic [16:0]           len_rx;
    logic                  xfer, data_byte, last_word;

    // start takes priority over a byte offered in the same cycle
    assign xfer      = in_valid && in_ready && !start;
    assign data_byte = xfer && (state == S_DATA);
    assign len_rx    = {1'b0, in_data, len_lo};
    assign last_word = (17'(word_idx) == (17'(len) - 17'd1));

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .byte_valid (data_byte),
        .byte_data  (in_data),
        .byte_cnt   (byte_cnt),
        .word_valid (mem_we),
        .word_data  (mem_wdata)
    );

    always_comb begin
        state_d    = state;
        err_code_d = err_code;
        if (start) begin
            state_d    = S_LEN_LO;
            err_code_d = ERR_NONE;
        end else if (xfer) begin
            case (state)
                S_LEN_LO: state_d = S_LEN_HI;
                S_LEN_HI: begin
                    if (len_rx == 17'd0) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_LEN_ZERO;
                    end else if (len_rx > 17'(MAX_WORDS)) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_LEN_OVF;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (byte_cnt == 2'd3 && last_word) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (in_data == csum) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_CSUM;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs are decoded from the next state so they are registered
    // yet line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            err_code  <= ERR_NONE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst_n <= 1'b0;
            len_lo    <= '0;
            len       <= '0;
            csum      <= '0;
            word_idx  <= '0;
            mem_addr  <= '0;
        end else begin
            state     <= state_d;
            err_code  <= err_code_d;
            in_ready  <= is_loading(state_d);
            busy      <= is_loading(state_d);
            done      <= (state_d == S_DONE);
            err       <= (state_d == S_ERROR);
            cpu_rst_n <= (state_d == S_DONE);
            if (start) begin
                len_lo   <= '0;
                len      <= '0;
                csum     <= '0;
                word_idx <= '0;
            end else if (xfer) begin
                case (state)
                    S_LEN_LO: len_lo <= in_data;
                    S_LEN_HI: begin
                        len      <= len_rx[15:0];
                        word_idx <= '0;
                    end
                    S_DATA: begin
                        csum <= csum ^ in_data;
                        if (byte_cnt == 2'd3) begin
                            mem_addr <= word_idx;
                            word_idx <= word_idx + ADDR_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes go into a scoreboard
// queue, and a monitor pops and compares them whenever mem_we is seen.
module tb_imem_loader;

    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned MAX_WORDS  = 1024;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  rst, start, in_valid;
    logic [7:0]            in_data;
    logic                  in_ready, mem_we, cpu_rst_n, busy, done, err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [1:0]            err_code;

    wr_t         exp_q[$];
    wr_t         exp_w;
    int          compared   = 0;
    int          mismatched = 0;
    int          stalls     = 0;
    logic        prev_we    = 1'b0;
    logic [7:0]  pl[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    // Monitor: every write must match the head of the scoreboard and last one cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%08h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if (mem_addr !== exp_w.addr || mem_wdata !== exp_w.data || prev_we) begin
                    mismatched++;
                    $display("FAIL mem_write: got addr=%0d data=0x%08h back_to_back=%0b, required addr=%0d data=0x%08h back_to_back=0",
                             mem_addr, mem_wdata, prev_we, exp_w.addr, exp_w.data);
                end
            end
        end
        prev_we = mem_we;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_write(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; returns 1 time unit after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned guard = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
            stalls++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 20 cycles, required 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [15:0] n, input logic [7:0] payload[$],
                              input logic [7:0] cs, input int unsigned gap_max);
        send_byte(n[7:0],  $urandom_range(gap_max, 0));
        send_byte(n[15:8], $urandom_range(gap_max, 0));
        foreach (payload[i]) send_byte(payload[i], $urandom_range(gap_max, 0));
        send_byte(cs, $urandom_range(gap_max, 0));
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  0);
        check("rst_busy",      busy,      0);
        check("rst_done",      done,      0);
        check("rst_err",       err,       0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_err_code",  err_code,  0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal two-word load; payload XOR = 13^05^A0^00^93^05^10^00 = 0x30.
        pl = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        push_write(0, 32'h00A00513);
        push_write(1, 32'h00100593);
        pulse_start();
        check("nom_busy", busy, 1);
        stalls = 0;
        send_frame(16'd2, pl, 8'h30, 0);
        check("nom_stalls",    stalls,    0);
        check("nom_done",      done,      1);
        check("nom_cpu_rst_n", cpu_rst_n, 1);
        check("nom_err",       err,       0);
        check("nom_in_ready",  in_ready,  0);

        // Same frame, wrong checksum: words still written, load fails.
        push_write(0, 32'h00A00513);
        push_write(1, 32'h00100593);
        pulse_start();
        check("bad_cs_restart_cpu_rst_n", cpu_rst_n, 0);
        send_frame(16'd2, pl, 8'h25, 0);
        check("bad_cs_err",       err,       1);
        check("bad_cs_err_code",  err_code,  3);
        check("bad_cs_cpu_rst_n", cpu_rst_n, 0);
        check("bad_cs_done",      done,      0);

        // Zero length: error straight after LEN_HI, nothing written.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        in_valid = 1'b0;
        check("len0_err",      err,      1);
        check("len0_err_code", err_code, 1);
        check("len0_in_ready", in_ready, 0);
        repeat (4) @(posedge clk);
        #1;

        // MAX_WORDS + 1 = 1025 = 0x0401.
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        in_valid = 1'b0;
        check("lenovf_err",      err,      1);
        check("lenovf_err_code", err_code, 2);

        // Throttled one-word frame; XOR 78^56^34^12 = 0x08.
        pl = '{8'h78, 8'h56, 8'h34, 8'h12};
        push_write(0, 32'h12345678);
        pulse_start();
        send_frame(16'd1, pl, 8'h08, 3);
        check("thr_done",      done,      1);
        check("thr_cpu_rst_n", cpu_rst_n, 1);
        check("thr_err_code",  err_code,  0);

        // Abort after two data bytes; the byte offered with the restart is dropped.
        push_write(0, 32'h000000FF);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        in_valid = 1'b1;
        in_data  = 8'hCC;
        pulse_start();
        in_valid = 1'b0;
        check("abort_busy",      busy,      1);
        check("abort_cpu_rst_n", cpu_rst_n, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("abort_pre_cs_cpu_rst_n", cpu_rst_n, 0);
        send_byte(8'hFF, 0);
        in_valid = 1'b0;
        check("abort_done",      done,      1);
        check("abort_cpu_rst_n_done", cpu_rst_n, 1);

        // Asynchronous reset in the middle of DATA.
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready",  in_ready,  0);
        check("arst_busy",      busy,      0);
        check("arst_done",      done,      0);
        check("arst_err",       err,       0);
        check("arst_cpu_rst_n", cpu_rst_n, 0);
        check("arst_mem_we",    mem_we,    0);
        check("arst_mem_addr",  mem_addr,  0);
        check("arst_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 0);
        check("post_rst_busy",     busy,     0);
        pulse_start();
        check("post_rst_start_in_ready", in_ready, 1);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
